// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared geometry helpers and state type for the conv datapath
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int out_dim(input int n, input int pad, input int f, input int s);
        return (n + 2 * pad - f) / s + 1;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rf_window_gather.sv
// rtl/rf_window_gather.sv - one lane's F x F x D window, zero outside the image
module rf_window_gather #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5
) (
    input  logic [0:D*H*W*DATA_WIDTH-1] image,
    input  logic signed [31:0]          y0,
    input  logic signed [31:0]          x0,
    input  logic                        en,
    output logic [0:D*F*F*DATA_WIDTH-1] window
);

    always_comb begin
        window = '0;
        for (int k = 0; k < D; k++) begin
            for (int i = 0; i < F; i++) begin
                for (int j = 0; j < F; j++) begin
                    // taps falling in the padding border stay zero
                    if (en && (y0 + i) >= 0 && (y0 + i) < H && (x0 + j) >= 0 && (x0 + j) < W) begin
                        window[((k * F + i) * F + j) * DATA_WIDTH +: DATA_WIDTH] =
                            image[((k * H + (y0 + i)) * W + (x0 + j)) * DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rf_stream_selector.sv
// rtl/rf_stream_selector.sv - latches an image and streams P receptive-field windows per beat
module rf_stream_selector
    import cnn_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  D          = 1,
    parameter int  H          = 32,
    parameter int  W          = 32,
    parameter int  F          = 5,
    parameter int  S          = 1,
    parameter int  PAD        = 0,
    parameter int  P          = 14,
    localparam int OH         = out_dim(H, PAD, F, S),
    localparam int OW         = out_dim(W, PAD, F, S),
    localparam int RFW        = P * D * F * F * DATA_WIDTH,
    localparam int RW         = safe_clog2(OH),
    localparam int CW         = safe_clog2(OW)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [0:D*H*W*DATA_WIDTH-1] image,
    output logic                        busy,
    output logic                        rf_valid,
    input  logic                        rf_ready,
    output logic [0:RFW-1]              receptive_field,
    output logic [RW-1:0]               rf_row,
    output logic [CW-1:0]               rf_col,
    output logic [0:P-1]                rf_lane_mask,
    output logic                        rf_last,
    output logic                        done
);

    localparam int G     = ceil_div(OW, P);
    localparam int GW    = safe_clog2(G);
    localparam int LANEW = D * F * F * DATA_WIDTH;

    state_t                      state, state_next;
    logic [0:D*H*W*DATA_WIDTH-1] img_q;
    logic [RW-1:0]               row_q;
    logic [GW-1:0]               grp_q;
    logic                        run, fire, grp_end, row_end;
    logic [0:P-1]                lane_en;
    logic [0:RFW-1]              lanes;
    logic signed [31:0]          win_y0;

    assign run     = (state == ST_RUN);
    assign fire    = run && rf_ready;
    assign grp_end = (grp_q == GW'(G - 1));
    assign row_end = (row_q == RW'(OH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (fire && row_end && grp_end) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q <= '0;
            row_q <= '0;
            grp_q <= '0;
        end else if (state == ST_IDLE && start) begin
            img_q <= image;
            row_q <= '0;
            grp_q <= '0;
        end else if (fire) begin
            if (grp_end) begin
                grp_q <= '0;
                row_q <= row_end ? '0 : row_q + 1'b1;
            end else begin
                grp_q <= grp_q + 1'b1;
            end
        end
    end

    assign win_y0 = 32'(int'(row_q) * S - PAD);

    for (genvar p = 0; p < P; p++) begin : g_lane
        logic signed [31:0] oc;
        logic signed [31:0] x0;
        assign oc         = 32'(int'(grp_q) * P + p);
        assign x0         = oc * S - PAD;
        // lanes past the right edge of the last group carry no position
        assign lane_en[p] = run && (oc < OW);

        rf_window_gather #(
            .DATA_WIDTH(DATA_WIDTH),
            .D         (D),
            .H         (H),
            .W         (W),
            .F         (F)
        ) u_gather (
            .image (img_q),
            .y0    (win_y0),
            .x0    (x0),
            .en    (lane_en[p]),
            .window(lanes[p*LANEW +: LANEW])
        );
    end

    always_comb begin
        busy            = run;
        rf_valid        = run;
        done            = (state == ST_DONE);
        rf_last         = run && row_end && grp_end;
        rf_row          = run ? row_q : '0;
        rf_col          = run ? CW'(int'(grp_q) * P) : '0;
        rf_lane_mask    = lane_en;
        receptive_field = lanes;
    end

endmodule

// File: tb/tb_rf_stream_selector.sv
// tb/tb_rf_stream_selector.sv - scoreboard bench for rf_stream_selector over three geometries
module tb_rf_stream_selector;

    localparam int MAXW = 1152;

    typedef struct {
        int                row;
        int                col;
        logic [0:3]        mask;
        logic              last;
        logic [0:MAXW-1]   data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic start_a, start_b, start_c, rdy_a, rdy_b, rdy_c, rand_rdy;
    logic [0:1023] img_a, img_b;
    logic [0:2047] img_c, tmp;

    logic busy_a, valid_a, last_a, done_a;
    logic [2:0] row_a, col_a;
    logic [0:2] mask_a;
    logic [0:431] rf_a;

    logic busy_b, valid_b, last_b, done_b;
    logic [1:0] row_b, col_b;
    logic [0:2] mask_b;
    logic [0:431] rf_b;

    logic busy_c, valid_c, last_c, done_c;
    logic [2:0] row_c, col_c;
    logic [0:3] mask_c;
    logic [0:1151] rf_c;

    rf_stream_selector #(.DATA_WIDTH(16), .D(1), .H(8), .W(8), .F(3), .S(1), .PAD(0), .P(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .image(img_a), .busy(busy_a),
        .rf_valid(valid_a), .rf_ready(rdy_a), .receptive_field(rf_a), .rf_row(row_a),
        .rf_col(col_a), .rf_lane_mask(mask_a), .rf_last(last_a), .done(done_a));

    rf_stream_selector #(.DATA_WIDTH(16), .D(1), .H(8), .W(8), .F(3), .S(2), .PAD(1), .P(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .image(img_b), .busy(busy_b),
        .rf_valid(valid_b), .rf_ready(rdy_b), .receptive_field(rf_b), .rf_row(row_b),
        .rf_col(col_b), .rf_lane_mask(mask_b), .rf_last(last_b), .done(done_b));

    rf_stream_selector #(.DATA_WIDTH(16), .D(2), .H(8), .W(8), .F(3), .S(1), .PAD(0), .P(4)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .image(img_c), .busy(busy_c),
        .rf_valid(valid_c), .rf_ready(rdy_c), .receptive_field(rf_c), .rf_row(row_c),
        .rf_col(col_c), .rf_lane_mask(mask_c), .rf_last(last_c), .done(done_c));

    // bench-side geometry of the three instances
    int c_d[3]   = '{1, 1, 2};
    int c_s[3]   = '{1, 2, 1};
    int c_pad[3] = '{0, 1, 0};
    int c_p[3]   = '{3, 3, 4};
    int c_o[3]   = '{6, 4, 6};

    int n_cmp = 0;
    int n_bad = 0;
    int ndone[3] = '{0, 0, 0};
    int last_acc[3] = '{0, 0, 0};
    exp_t qa[$], qb[$], qc[$];
    exp_t rxa[$], rxb[$], rxc[$];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_data(input string nm, input logic [0:MAXW-1] act, input logic [0:MAXW-1] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int w = 0; w < MAXW / 16; w++) begin
                if (act[w*16 +: 16] !== exp[w*16 +: 16]) begin
                    $display("FAIL %s: word %0d got %h, expected %h", nm, w, act[w*16 +: 16], exp[w*16 +: 16]);
                    break;
                end
            end
        end
    endtask

    task automatic check_words(input string nm, input logic [0:MAXW-1] d, input int first, input int v[9]);
        logic ok = 1'b1;
        int bad = 0;
        n_cmp++;
        for (int t = 0; t < 9; t++) begin
            if (ok && d[(first + t)*16 +: 16] !== 16'(v[t])) begin
                ok = 1'b0;
                bad = t;
            end
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: word %0d got %0d, expected %0d", nm, first + bad, d[(first + bad)*16 +: 16], v[bad]);
        end
    endtask

    function automatic logic [0:2047] pattern(input logic alt);
        logic [0:2047] r;
        for (int i = 0; i < 128; i++) r[i*16 +: 16] = alt ? 16'(16'hA000 + i) : 16'(i);
        return r;
    endfunction

    // pixel value k*64 + y*8 + x equals its word index in every image used here
    function automatic exp_t model(input int n, input int row, input int grp);
        exp_t e;
        int d = c_d[n], s = c_s[n], pad = c_pad[n], p = c_p[n], o = c_o[n];
        int g = (o + p - 1) / p;
        e.row = row;
        e.col = grp * p;
        e.last = (row == o - 1) && (grp == g - 1);
        e.mask = '0;
        e.data = '0;
        for (int lane = 0; lane < p; lane++) begin
            int oc = grp * p + lane;
            if (oc < o) begin
                e.mask[lane] = 1'b1;
                for (int k = 0; k < d; k++)
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++) begin
                            int y = row * s - pad + i;
                            int x = oc * s - pad + j;
                            if (y >= 0 && y < 8 && x >= 0 && x < 8)
                                e.data[(lane*d*9 + k*9 + i*3 + j)*16 +: 16] = 16'(k*64 + y*8 + x);
                        end
            end
        end
        return e;
    endfunction

    task automatic push_frame(input int n);
        int g = (c_o[n] + c_p[n] - 1) / c_p[n];
        for (int r = 0; r < c_o[n]; r++)
            for (int gg = 0; gg < g; gg++) begin
                case (n)
                    0: qa.push_back(model(n, r, gg));
                    1: qb.push_back(model(n, r, gg));
                    default: qc.push_back(model(n, r, gg));
                endcase
            end
    endtask

    function automatic int qsize(input int n);
        return (n == 0) ? qa.size() : (n == 1) ? qb.size() : qc.size();
    endfunction

    function automatic int rxsize(input int n);
        return (n == 0) ? rxa.size() : (n == 1) ? rxb.size() : rxc.size();
    endfunction

    task automatic rx_clear(input int n);
        case (n)
            0: rxa.delete();
            1: rxb.delete();
            default: rxc.delete();
        endcase
    endtask

    task automatic check_beat(input int n, input int row, input int col, input logic [0:3] mask,
                              input logic last, input logic [0:MAXW-1] data);
        exp_t e, got;
        string pfx = (n == 0) ? "a" : (n == 1) ? "b" : "c";
        got.row = row; got.col = col; got.mask = mask; got.last = last; got.data = data;
        last_acc[n] = cyc;
        case (n)
            0: rxa.push_back(got);
            1: rxb.push_back(got);
            default: rxc.push_back(got);
        endcase
        if (qsize(n) == 0) begin
            cmp({pfx, "_unexpected_beat"}, 1, 0);
            return;
        end
        case (n)
            0: e = qa.pop_front();
            1: e = qb.pop_front();
            default: e = qc.pop_front();
        endcase
        cmp({pfx, "_rf_row"}, 64'(row), 64'(e.row));
        cmp({pfx, "_rf_col"}, 64'(col), 64'(e.col));
        cmp({pfx, "_rf_lane_mask"}, 64'(mask), 64'(e.mask));
        cmp({pfx, "_rf_last"}, 64'(last), 64'(e.last));
        cmp_data({pfx, "_receptive_field"}, data, e.data);
    endtask

    // monitor: consumes accepted beats, done pulses and stall holds
    logic hold_v = 1'b0;
    logic [0:431] h_rf;
    logic [2:0] h_row, h_col;
    logic [0:2] h_mask;
    logic h_last;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (valid_a && rdy_a) check_beat(0, row_a, col_a, {mask_a, 1'b0}, last_a, {rf_a, 720'b0});
                if (valid_b && rdy_b) check_beat(1, row_b, col_b, {mask_b, 1'b0}, last_b, {rf_b, 720'b0});
                if (valid_c && rdy_c) check_beat(2, row_c, col_c, mask_c, last_c, rf_c);
                if (done_a) begin cmp("a_done_timing", cyc, last_acc[0] + 1); cmp("a_busy_in_done", busy_a, 0); ndone[0]++; end
                if (done_b) begin cmp("b_done_timing", cyc, last_acc[1] + 1); ndone[1]++; end
                if (done_c) begin cmp("c_done_timing", cyc, last_acc[2] + 1); ndone[2]++; end
                if (hold_v)
                    cmp("a_stall_hold", (valid_a === 1'b1) && (rf_a === h_rf) && (row_a === h_row) &&
                        (col_a === h_col) && (mask_a === h_mask) && (last_a === h_last), 1);
                hold_v = valid_a && !rdy_a;
                h_rf = rf_a; h_row = row_a; h_col = col_a; h_mask = mask_a; h_last = last_a;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rdy_a = 1'($urandom_range(0, 1));
        end
    end

    task automatic kick(input int n);
        @(posedge clk); #1;
        case (n)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        cmp($sformatf("i%0d_first_beat_latency", n), (n == 0) ? valid_a : (n == 1) ? valid_b : valid_c, 1);
    endtask

    task automatic wait_done(input int n, input int beats);
        int prev = ndone[n];
        int t = 0;
        while (ndone[n] == prev && t < 300) begin
            @(posedge clk);
            t++;
        end
        cmp($sformatf("i%0d_done_seen", n), 64'(ndone[n] > prev), 1);
        @(negedge clk); #1;
        cmp($sformatf("i%0d_queue_drained", n), qsize(n), 0);
        cmp($sformatf("i%0d_beat_count", n), rxsize(n), beats);
    endtask

    task automatic check_a_zero(input string nm);
        cmp({nm, "_valid"}, valid_a, 0);
        cmp({nm, "_busy"}, busy_a, 0);
        cmp({nm, "_done"}, done_a, 0);
        cmp({nm, "_last"}, last_a, 0);
        cmp({nm, "_row"}, row_a, 0);
        cmp({nm, "_col"}, col_a, 0);
        cmp({nm, "_mask"}, mask_a, 0);
        cmp_data({nm, "_rf"}, {rf_a, 720'b0}, '0);
    endtask

    initial begin
        int t;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1; rand_rdy = 1'b0;
        tmp = pattern(1'b0);
        img_a = tmp[0:1023]; img_b = tmp[0:1023]; img_c = tmp;

        #1 rst_n = 1'b0;
        #2 check_a_zero("reset");
        cmp("reset_c_valid", valid_c, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ready held high: 12 beats, beat 0 / beat 1 contents
        push_frame(0); rx_clear(0); kick(0); wait_done(0, 12);
        check_words("a_beat0_lane0", rxa[0].data, 0, '{0, 1, 2, 8, 9, 10, 16, 17, 18});
        cmp("a_beat1_col", rxa[1].col, 3);
        check_words("a_beat1_lane0", rxa[1].data, 0, '{3, 4, 5, 11, 12, 13, 19, 20, 21});
        cmp("a_beat11_last", rxa[11].last, 1);
        cmp("a_beat10_not_last", rxa[10].last, 0);

        // random backpressure, image rewritten after latch, extra start while busy
        push_frame(0); rx_clear(0); rand_rdy = 1'b1; kick(0);
        tmp = pattern(1'b1); img_a = tmp[0:1023];
        repeat (4) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done(0, 12);
        rand_rdy = 1'b0; rdy_a = 1'b1;
        repeat (5) @(posedge clk);
        #1 cmp("a_extra_start_ignored", rxa.size(), 12);

        // padding and stride
        push_frame(1); rx_clear(1); kick(1); wait_done(1, 8);
        check_words("b_beat0_lane0", rxb[0].data, 0, '{0, 0, 0, 0, 0, 1, 0, 8, 9});
        cmp("b_beat7_row", rxb[7].row, 3);
        cmp("b_beat7_col", rxb[7].col, 3);
        check_words("b_beat7_lane0", rxb[7].data, 0, '{45, 46, 47, 53, 54, 55, 61, 62, 63});
        cmp("b_beat1_mask", rxb[1].mask, 4'b1000);

        // two channels, partial group of four lanes
        push_frame(2); rx_clear(2); kick(2); wait_done(2, 12);
        check_words("c_beat0_ch0", rxc[0].data, 0, '{0, 1, 2, 8, 9, 10, 16, 17, 18});
        check_words("c_beat0_ch1", rxc[0].data, 9, '{64, 65, 66, 72, 73, 74, 80, 81, 82});
        cmp("c_beat1_mask", rxc[1].mask, 4'b1100);
        cmp("c_beat0_mask", rxc[0].mask, 4'b1111);
        cmp_data("c_beat1_lanes23_zero", {rxc[1].data[576:1151], 576'b0}, '0);

        // reset during beat 5, then a clean restart
        tmp = pattern(1'b0); img_a = tmp[0:1023];
        push_frame(0); rx_clear(0); kick(0);
        t = 0;
        while (rxa.size() < 6 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        cmp("a_reached_beat5", rxa.size(), 6);
        #1 rst_n = 1'b0;
        #1 check_a_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        qa.delete();
        push_frame(0); rx_clear(0); kick(0); wait_done(0, 12);
        cmp("restart_row", rxa[0].row, 0);
        cmp("restart_col", rxa[0].col, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
